// File: rtl/bus_source_arbiter_3ch_if.sv
// Bus-side signals between the three request sources, the arbiter and the
// downstream 3-channel mux/consumer.
interface bus_source_arbiter_3ch_if;
    logic [2:0] req;
    logic [1:0] sel;
    logic [2:0] grant;
    logic       valid;

    modport master (
        input  req,
        output sel,
        output grant,
        output valid
    );

    modport slave (
        output req,
        input  sel,
        input  grant,
        input  valid
    );
endinterface

// File: rtl/bus_source_arbiter_3ch.sv
// Round-robin arbiter (A->B->C->A) driving the select of a 3-channel bus mux,
// with a hold limit that forces rotation when another channel is waiting.
module bus_source_arbiter_3ch #(
    parameter int unsigned MAX_HOLD = 4
) (
    input logic                      clk,
    input logic                      rst,
    bus_source_arbiter_3ch_if.master bus
);

    localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        StIdle,
        StOwnA,
        StOwnB,
        StOwnC
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       last_q, last_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    logic       go;
    logic [1:0] go_ch;
    logic [1:0] own;
    logic [2:0] others;

    // First requester strictly after ref_ch in A->B->C order, ref_ch itself last.
    function automatic logic [1:0] pick(input logic [1:0] ref_ch, input logic [2:0] mask);
        logic [1:0] ch;
        case (ref_ch)
            2'd0: begin
                if (mask[1])      ch = 2'd1;
                else if (mask[2]) ch = 2'd2;
                else              ch = 2'd0;
            end
            2'd1: begin
                if (mask[2])      ch = 2'd2;
                else if (mask[0]) ch = 2'd0;
                else              ch = 2'd1;
            end
            default: begin
                if (mask[0])      ch = 2'd0;
                else if (mask[1]) ch = 2'd1;
                else              ch = 2'd2;
            end
        endcase
        return ch;
    endfunction

    function automatic state_e own_state(input logic [1:0] ch);
        state_e st;
        case (ch)
            2'd0:    st = StOwnA;
            2'd1:    st = StOwnB;
            default: st = StOwnC;
        endcase
        return st;
    endfunction

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        go      = 1'b0;
        go_ch   = 2'd0;
        own     = 2'd0;
        others  = 3'b000;

        unique case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    go    = 1'b1;
                    go_ch = pick(last_q, bus.req);
                end
            end
            default: begin
                own    = (state_q == StOwnA) ? 2'd0 : (state_q == StOwnB) ? 2'd1 : 2'd2;
                others = bus.req & ~(3'b001 << own);
                if (!bus.req[own]) begin
                    if (|others) begin
                        go    = 1'b1;
                        go_ch = pick(own, others);
                    end else begin
                        state_d = StIdle;
                    end
                end else if ((hold_q == HOLD_LAST) && (|others)) begin
                    go    = 1'b1;
                    go_ch = pick(own, others);
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
        endcase

        if (go) begin
            state_d = own_state(go_ch);
            hold_d  = '0;
            last_d  = go_ch;
            sel_d   = go_ch;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            last_q  <= 2'd2;
            sel_q   <= 2'd0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
        end
    end

    // Outputs depend only on flops; sel holds its last value while idle.
    always_comb begin
        bus.sel   = sel_q;
        bus.valid = (state_q != StIdle);
        unique case (state_q)
            StOwnA:  bus.grant = 3'b001;
            StOwnB:  bus.grant = 3'b010;
            StOwnC:  bus.grant = 3'b100;
            default: bus.grant = 3'b000;
        endcase
    end

endmodule
